// File: rtl/rv32i_types.sv
// Shared RV32I types: ALU operation encoding and the ALU reservation-station entry.
// Entry tags use RS_TAG_W; alu_issue_queue expects its TAG_W to match this width.
package rv32i_types;

    localparam int unsigned RS_TAG_W = 4;

    typedef enum logic [2:0] {
        alu_add = 3'b000,
        alu_sll = 3'b001,
        alu_sra = 3'b010,
        alu_sub = 3'b011,
        alu_xor = 3'b100,
        alu_srl = 3'b101,
        alu_or  = 3'b110,
        alu_and = 3'b111
    } alu_ops;

    typedef struct packed {
        logic                valid;
        alu_ops              aluop;
        logic [RS_TAG_W-1:0] rob_id;
        logic                src1_rdy;
        logic [RS_TAG_W-1:0] src1_tag;
        logic [31:0]         src1_val;
        logic                src2_rdy;
        logic [RS_TAG_W-1:0] src2_tag;
        logic [31:0]         src2_val;
    } rs_entry_t;

endpackage

// File: rtl/alu.sv
// Combinational RV32I integer ALU.
module alu
    import rv32i_types::*;
(
    input  alu_ops      aluop,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] f
);

    always_comb begin
        f = '0;
        case (aluop)
            alu_add: f = a + b;
            alu_sll: f = a << b[4:0];
            alu_sra: f = $signed(a) >>> b[4:0];
            alu_sub: f = a - b;
            alu_xor: f = a ^ b;
            alu_srl: f = a >> b[4:0];
            alu_or:  f = a | b;
            alu_and: f = a & b;
            default: f = '0;
        endcase
    end

endmodule

// File: rtl/alu_issue_queue.sv
// ALU reservation station: operand wakeup from the CDB, oldest-ready select via an
// age matrix, one issue per cycle into a registered result stage.
module alu_issue_queue
    import rv32i_types::*;
#(
    parameter int unsigned RS_DEPTH = 4,
    parameter int unsigned TAG_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dispatch_valid,
    output logic             dispatch_ready,
    input  logic [2:0]       dispatch_aluop,
    input  logic [TAG_W-1:0] dispatch_rob_id,
    input  logic             dispatch_src1_rdy,
    input  logic [TAG_W-1:0] dispatch_src1_tag,
    input  logic [31:0]      dispatch_src1_val,
    input  logic             dispatch_src2_rdy,
    input  logic [TAG_W-1:0] dispatch_src2_tag,
    input  logic [31:0]      dispatch_src2_val,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [31:0]      cdb_val,
    input  logic             flush,
    output logic [2:0]       alu_aluop,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    input  logic [31:0]      alu_f,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [TAG_W-1:0] res_rob_id,
    output logic [31:0]      res_data
);

    localparam int unsigned IDX_W = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;

    rs_entry_t           q     [RS_DEPTH];
    logic [RS_DEPTH-1:0] older [RS_DEPTH];  // older[i][j]: entry i dispatched before entry j
    logic [RS_DEPTH-1:0] elig;
    logic [IDX_W-1:0]    free_idx;
    logic [IDX_W-1:0]    sel_idx;
    logic                have_free;
    logic                have_sel;
    logic                issue;
    logic                dispatch_fire;
    logic [RS_TAG_W-1:0] cdb_tag_e;
    rs_entry_t           new_entry;
    logic [31:0]         ref_f;

    assign cdb_tag_e      = RS_TAG_W'(cdb_tag);
    assign dispatch_ready = have_free;
    assign dispatch_fire  = dispatch_valid && have_free;
    assign issue          = have_sel && (!res_valid || res_ready);

    // Lowest-index free entry
    always_comb begin
        have_free = 1'b0;
        free_idx  = '0;
        for (int i = int'(RS_DEPTH) - 1; i >= 0; i--) begin
            if (!q[i].valid) begin
                have_free = 1'b1;
                free_idx  = IDX_W'(i);
            end
        end
    end

    // Oldest eligible entry: no other eligible entry is older than it
    always_comb begin
        logic beaten;
        beaten   = 1'b0;
        have_sel = 1'b0;
        sel_idx  = '0;
        for (int i = 0; i < int'(RS_DEPTH); i++) begin
            elig[i] = q[i].valid && q[i].src1_rdy && q[i].src2_rdy;
        end
        for (int i = 0; i < int'(RS_DEPTH); i++) begin
            beaten = 1'b0;
            for (int j = 0; j < int'(RS_DEPTH); j++) begin
                if (elig[j] && older[j][i]) beaten = 1'b1;
            end
            if (elig[i] && !beaten) begin
                have_sel = 1'b1;
                sel_idx  = IDX_W'(i);
            end
        end
    end

    always_comb begin
        alu_aluop = '0;
        alu_a     = '0;
        alu_b     = '0;
        if (issue) begin
            alu_aluop = q[sel_idx].aluop;
            alu_a     = q[sel_idx].src1_val;
            alu_b     = q[sel_idx].src2_val;
        end
    end

    // Incoming entry, capturing a same-cycle CDB broadcast for not-ready operands
    always_comb begin
        new_entry          = '0;
        new_entry.valid    = 1'b1;
        new_entry.aluop    = alu_ops'(dispatch_aluop);
        new_entry.rob_id   = RS_TAG_W'(dispatch_rob_id);
        new_entry.src1_tag = RS_TAG_W'(dispatch_src1_tag);
        new_entry.src2_tag = RS_TAG_W'(dispatch_src2_tag);
        new_entry.src1_rdy = dispatch_src1_rdy ||
                             (cdb_valid && RS_TAG_W'(dispatch_src1_tag) == cdb_tag_e);
        new_entry.src2_rdy = dispatch_src2_rdy ||
                             (cdb_valid && RS_TAG_W'(dispatch_src2_tag) == cdb_tag_e);
        new_entry.src1_val = dispatch_src1_rdy ? dispatch_src1_val : cdb_val;
        new_entry.src2_val = dispatch_src2_rdy ? dispatch_src2_val : cdb_val;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(RS_DEPTH); i++) begin
                q[i]     <= '0;
                older[i] <= '0;
            end
            res_valid  <= 1'b0;
            res_rob_id <= '0;
            res_data   <= '0;
        end else begin
            for (int i = 0; i < int'(RS_DEPTH); i++) begin
                if (q[i].valid && cdb_valid) begin
                    if (!q[i].src1_rdy && q[i].src1_tag == cdb_tag_e) begin
                        q[i].src1_rdy <= 1'b1;
                        q[i].src1_val <= cdb_val;
                    end
                    if (!q[i].src2_rdy && q[i].src2_tag == cdb_tag_e) begin
                        q[i].src2_rdy <= 1'b1;
                        q[i].src2_val <= cdb_val;
                    end
                end
            end
            if (issue) q[sel_idx].valid <= 1'b0;
            if (dispatch_fire) begin
                q[free_idx] <= new_entry;
                for (int j = 0; j < int'(RS_DEPTH); j++) begin
                    if (j != int'(free_idx)) begin
                        older[free_idx][j] <= 1'b0;
                        older[j][free_idx] <= 1'b1;
                    end
                end
            end
            if (flush) begin
                for (int i = 0; i < int'(RS_DEPTH); i++) q[i].valid <= 1'b0;
            end

            if (flush) begin
                res_valid <= 1'b0;
            end else if (issue) begin
                res_valid  <= 1'b1;
                res_rob_id <= TAG_W'(q[sel_idx].rob_id);
                res_data   <= alu_f;
            end else if (res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

    alu u_alu (
        .aluop (alu_ops'(alu_aluop)),
        .a     (alu_a),
        .b     (alu_b),
        .f     (ref_f)
    );

    // The external ALU result captured on issue must agree with the local ALU
    always_ff @(posedge clk) begin
        if (!rst && issue) assert (alu_f == ref_f);
    end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue; the external ALU is modelled independently here.
module tb_alu_issue_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        dispatch_valid;
    logic        dispatch_ready;
    logic [2:0]  dispatch_aluop;
    logic [3:0]  dispatch_rob_id;
    logic        dispatch_src1_rdy;
    logic [3:0]  dispatch_src1_tag;
    logic [31:0] dispatch_src1_val;
    logic        dispatch_src2_rdy;
    logic [3:0]  dispatch_src2_tag;
    logic [31:0] dispatch_src2_val;
    logic        cdb_valid;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_val;
    logic        flush;
    logic [2:0]  alu_aluop;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_f;
    logic        res_valid;
    logic        res_ready;
    logic [3:0]  res_rob_id;
    logic [31:0] res_data;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_issue_queue #(.RS_DEPTH(4), .TAG_W(4)) dut (
        .clk               (clk),
        .rst               (rst),
        .dispatch_valid    (dispatch_valid),
        .dispatch_ready    (dispatch_ready),
        .dispatch_aluop    (dispatch_aluop),
        .dispatch_rob_id   (dispatch_rob_id),
        .dispatch_src1_rdy (dispatch_src1_rdy),
        .dispatch_src1_tag (dispatch_src1_tag),
        .dispatch_src1_val (dispatch_src1_val),
        .dispatch_src2_rdy (dispatch_src2_rdy),
        .dispatch_src2_tag (dispatch_src2_tag),
        .dispatch_src2_val (dispatch_src2_val),
        .cdb_valid         (cdb_valid),
        .cdb_tag           (cdb_tag),
        .cdb_val           (cdb_val),
        .flush             (flush),
        .alu_aluop         (alu_aluop),
        .alu_a             (alu_a),
        .alu_b             (alu_b),
        .alu_f             (alu_f),
        .res_valid         (res_valid),
        .res_ready         (res_ready),
        .res_rob_id        (res_rob_id),
        .res_data          (res_data)
    );

    // Reference ALU: add=0 sll=1 sra=2 sub=3 xor=4 srl=5 or=6 and=7
    always_comb begin
        case (alu_aluop)
            3'd0:    alu_f = alu_a + alu_b;
            3'd1:    alu_f = alu_a << alu_b[4:0];
            3'd2:    alu_f = $signed(alu_a) >>> alu_b[4:0];
            3'd3:    alu_f = alu_a - alu_b;
            3'd4:    alu_f = alu_a ^ alu_b;
            3'd5:    alu_f = alu_a >> alu_b[4:0];
            3'd6:    alu_f = alu_a | alu_b;
            default: alu_f = alu_a & alu_b;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic disp(input logic v, input logic [2:0] op, input logic [3:0] rob,
                        input logic r1, input logic [3:0] t1, input logic [31:0] v1,
                        input logic r2, input logic [3:0] t2, input logic [31:0] v2);
        dispatch_valid    = v;
        dispatch_aluop    = op;
        dispatch_rob_id   = rob;
        dispatch_src1_rdy = r1;
        dispatch_src1_tag = t1;
        dispatch_src1_val = v1;
        dispatch_src2_rdy = r2;
        dispatch_src2_tag = t2;
        dispatch_src2_val = v2;
    endtask

    task automatic cdb(input logic v, input logic [3:0] t, input logic [31:0] d);
        cdb_valid = v;
        cdb_tag   = t;
        cdb_val   = d;
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        res_ready = 1'b1;
        disp(1'b0, 3'd0, 4'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        cdb(1'b0, 4'd0, 32'd0);
        repeat (3) tick();
        rst = 1'b0;
        #1;
        chk("rst_dispatch_ready", 32'(dispatch_ready), 32'd1);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_rob_id", 32'(res_rob_id), 32'd0);
        chk("rst_res_data", res_data, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_b", alu_b, 32'd0);
        chk("rst_alu_aluop", 32'(alu_aluop), 32'd0);

        // add 5+7: issue next cycle, result the cycle after
        disp(1'b1, 3'd0, 4'd1, 1'b1, 4'd0, 32'd5, 1'b1, 4'd0, 32'd7);
        tick();
        dispatch_valid = 1'b0;
        #1;
        chk("add_alu_a", alu_a, 32'd5);
        chk("add_alu_b", alu_b, 32'd7);
        tick(); #1;
        chk("add_res_valid", 32'(res_valid), 32'd1);
        chk("add_res_data", res_data, 32'd12);
        chk("add_res_rob", 32'(res_rob_id), 32'd1);
        chk("add_idle_alu_a", alu_a, 32'd0);
        tick(); #1;
        chk("add_drained", 32'(res_valid), 32'd0);

        // sub 25-x, x arrives on the CDB with tag 3
        disp(1'b1, 3'd3, 4'd2, 1'b1, 4'd0, 32'd25, 1'b0, 4'd3, 32'd0);
        tick();
        dispatch_valid = 1'b0;
        #1;
        chk("sub_wait_alu_a", alu_a, 32'd0);
        tick();
        cdb(1'b1, 4'd3, 32'd10);
        #1;
        chk("sub_wake_no_issue", alu_a, 32'd0);
        tick();
        cdb(1'b0, 4'd0, 32'd0);
        #1;
        chk("sub_alu_aluop", 32'(alu_aluop), 32'd3);
        chk("sub_alu_a", alu_a, 32'd25);
        chk("sub_alu_b", alu_b, 32'd10);
        tick(); #1;
        chk("sub_res_data", res_data, 32'd15);
        chk("sub_res_rob", 32'(res_rob_id), 32'd2);
        tick();

        // fill all four entries with not-ready src1
        disp(1'b1, 3'd0, 4'd3, 1'b0, 4'd5, 32'd0, 1'b1, 4'd0, 32'd1);
        tick();
        disp(1'b1, 3'd4, 4'd4, 1'b0, 4'd6, 32'd0, 1'b1, 4'd0, 32'h0000_00f0);
        tick();
        disp(1'b1, 3'd0, 4'd5, 1'b0, 4'd7, 32'd0, 1'b1, 4'd0, 32'd1);
        tick();
        disp(1'b1, 3'd6, 4'd6, 1'b0, 4'd8, 32'd0, 1'b1, 4'd0, 32'h0000_000f);
        tick();
        disp(1'b1, 3'd0, 4'd7, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0, 32'd1);
        #1;
        chk("full_ready_low", 32'(dispatch_ready), 32'd0);
        tick();
        cdb(1'b1, 4'd5, 32'd100);
        #1;
        chk("full_held_ready_low", 32'(dispatch_ready), 32'd0);
        chk("full_no_issue", alu_a, 32'd0);
        tick();
        cdb(1'b0, 4'd0, 32'd0);
        #1;
        chk("full_issue_alu_a", alu_a, 32'd100);
        chk("full_issue_alu_b", alu_b, 32'd1);
        chk("full_issue_not_free", 32'(dispatch_ready), 32'd0);
        tick(); #1;
        chk("freed_ready_high", 32'(dispatch_ready), 32'd1);
        chk("full_res_data", res_data, 32'd101);
        chk("full_res_rob", 32'(res_rob_id), 32'd3);
        tick();
        dispatch_valid = 1'b0;
        #1;
        chk("fifth_alu_a", alu_a, 32'd1);
        chk("fifth_full_again", 32'(dispatch_ready), 32'd0);
        tick(); #1;
        chk("fifth_res_data", res_data, 32'd2);
        chk("fifth_res_rob", 32'(res_rob_id), 32'd7);

        // A (younger, entry 0) and B (older, entry 2) both wait on tag 7
        disp(1'b1, 3'd3, 4'd8, 1'b1, 4'd0, 32'd50, 1'b0, 4'd7, 32'd0);
        tick();
        dispatch_valid = 1'b0;
        cdb(1'b1, 4'd7, 32'd20);
        #1;
        chk("age_wake_no_issue", alu_a, 32'd0);
        tick();
        cdb(1'b0, 4'd0, 32'd0);
        res_ready = 1'b0;
        #1;
        chk("age_older_first_a", alu_a, 32'd20);
        chk("age_older_first_b", alu_b, 32'd1);
        chk("age_older_first_op", 32'(alu_aluop), 32'd0);
        tick(); #1;
        chk("stall_res_valid", 32'(res_valid), 32'd1);
        chk("stall_res_data", res_data, 32'd21);
        chk("stall_res_rob", 32'(res_rob_id), 32'd5);
        chk("stall_no_issue", alu_a, 32'd0);
        tick(); #1;
        chk("stall_hold_data", res_data, 32'd21);
        chk("stall_hold_valid", 32'(res_valid), 32'd1);
        chk("stall_hold_no_issue", alu_a, 32'd0);
        res_ready = 1'b1;
        #1;
        chk("drain_issue_op", 32'(alu_aluop), 32'd3);
        chk("drain_issue_a", alu_a, 32'd50);
        chk("drain_issue_b", alu_b, 32'd20);
        tick(); #1;
        chk("b2b_res_valid", 32'(res_valid), 32'd1);
        chk("b2b_res_data", res_data, 32'd30);
        chk("b2b_res_rob", 32'(res_rob_id), 32'd8);

        // flush with three queued entries and a held result
        res_ready = 1'b0;
        disp(1'b1, 3'd7, 4'd9, 1'b0, 4'd10, 32'd0, 1'b1, 4'd0, 32'h0000_000f);
        tick();
        disp(1'b1, 3'd0, 4'd10, 1'b1, 4'd0, 32'd3, 1'b1, 4'd0, 32'd4);
        cdb(1'b1, 4'd6, 32'd5);
        flush = 1'b1;
        #1;
        chk("preflush_res_data", res_data, 32'd30);
        tick();
        flush = 1'b0;
        dispatch_valid = 1'b0;
        res_ready = 1'b1;
        cdb(1'b1, 4'd8, 32'd9);
        #1;
        chk("flush_res_valid", 32'(res_valid), 32'd0);
        chk("flush_ready", 32'(dispatch_ready), 32'd1);
        chk("flush_no_issue", alu_a, 32'd0);
        tick();
        cdb(1'b1, 4'd10, 32'd9);
        #1;
        chk("flush_stale_e3", alu_a, 32'd0);
        chk("flush_res_idle", 32'(res_valid), 32'd0);
        tick();
        cdb(1'b0, 4'd0, 32'd0);
        #1;
        chk("flush_stale_e0", alu_a, 32'd0);

        // dispatch-time capture of a same-cycle CDB broadcast
        disp(1'b1, 3'd3, 4'd11, 1'b0, 4'd11, 32'd0, 1'b1, 4'd0, 32'd2);
        cdb(1'b1, 4'd11, 32'd40);
        tick();
        dispatch_valid = 1'b0;
        cdb(1'b0, 4'd0, 32'd0);
        #1;
        chk("dcap_alu_a", alu_a, 32'd40);
        chk("dcap_alu_b", alu_b, 32'd2);
        tick(); #1;
        chk("dcap_res_data", res_data, 32'd38);
        chk("dcap_res_rob", 32'(res_rob_id), 32'd11);
        tick(); #1;
        chk("dcap_drained", 32'(res_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_issue_queue.md
ALU_ISSUE_QUEUE -- requirements
Module: alu_issue_queue

Interface
REQ-001 SHALL have parameter RS_DEPTH, default 4, meaning number of reservation-station entries (power of two, 2..8).
REQ-002 SHALL have parameter TAG_W, default 4, meaning ROB-index/physical-tag width.
REQ-003 SHALL have clk input 1 (the single clock) and rst input 1 (synchronous, active-high reset); all state updates on the rising edge of clk.
REQ-004 dispatch_valid in 1, dispatch_ready out 1: dispatch handshake; transfer when both high.
REQ-005 dispatch_aluop in 3, the ALU operation, rv32i_types alu_ops encoding; dispatch_rob_id in TAG_W, destination tag.
REQ-006 dispatch_src1_rdy in 1, dispatch_src1_tag in TAG_W, dispatch_src1_val in 32; src2 identical; a value is valid only when its rdy bit is high.
REQ-007 cdb_valid in 1, cdb_tag in TAG_W, cdb_val in 32: result broadcast used for operand wakeup.
REQ-008 flush in 1: discard all queued and in-flight work.
REQ-009 alu_aluop out 3, alu_a out 32, alu_b out 32 to the ALU; alu_f in 32, the ALU's combinational result.
REQ-010 res_valid out 1, res_ready in 1, res_rob_id out TAG_W, res_data out 32: result output handshake.

Function
REQ-011 Each entry SHALL hold valid, aluop, rob_id, per-operand rdy/tag/value; free entries have valid=0.
REQ-012 dispatch_ready SHALL be high iff at least one entry is free in current registered state (does not count a same-cycle issue).
REQ-013 On dispatch, the lowest-index free entry SHALL be written.
REQ-014 If cdb_valid and cdb_tag matches a not-ready dispatch operand in the same cycle, the entry SHALL store cdb_val with rdy=1.
REQ-015 Each cycle cdb_valid is high, every valid entry with a not-ready operand whose tag equals cdb_tag SHALL capture cdb_val and set rdy; both operands may wake in one cycle.
REQ-016 An entry is eligible when valid and both operands rdy in registered state; an entry woken in cycle t is first eligible in cycle t+1.
REQ-017 Select SHALL pick the oldest eligible entry by dispatch order (age matrix or equivalent); index order SHALL NOT decide age.
REQ-018 Issue SHALL occur iff an eligible entry exists and (!res_valid || res_ready); at most one issue per cycle.
REQ-019 On issue in cycle t: alu_aluop/alu_a/alu_b SHALL carry the selected entry (src1->a, src2->b); alu_f and rob_id are registered; res_valid is high from t+1; the entry is freed at t+1.
REQ-020 When not issuing, alu_aluop/alu_a/alu_b SHALL be driven to 0.
REQ-021 res_valid/res_rob_id/res_data SHALL hold stable while res_valid && !res_ready; issue and drain in the same cycle give back-to-back results with no bubble.
REQ-022 Dispatch into a just-freed entry is permitted only from the following cycle (per REQ-012).
REQ-023 flush SHALL clear all entry valids and res_valid at the next edge, overriding same-cycle dispatch, issue and wakeup; dispatch_ready is high the cycle after.
REQ-024 Simultaneous dispatch, wakeup, issue and drain in one cycle SHALL all take effect.

Reset
REQ-025 While rst is high at an edge: all entry valids 0, age state cleared, res_valid 0, res_rob_id 0, res_data 0; rst dominates flush.
REQ-026 After reset dispatch_ready SHALL be 1 and the ALU-facing outputs 0.

Structure
REQ-027 alu_ops enum and an rs_entry_t struct (parameterised by TAG_W constant) SHALL be in the shared rv32i_types package.
REQ-028 The block SHALL instantiate one alu as the sole sub-module; the age-based select is internal logic.

Verification
REQ-029 Dispatch add, src1=5 rdy, src2=7 rdy at cycle 0 -> issue cycle 1, res_valid=1, res_data=12 at cycle 2.
REQ-030 Dispatch sub with src2 tag 3 not ready; cdb_valid tag 3 val 10 at cycle 4, src1=25 -> issue cycle 5, res_data=15 at cycle 6.
REQ-031 Fill 4 entries not-ready -> dispatch_ready=0; 5th dispatch_valid held, not accepted until an entry frees.
REQ-032 Entries dispatched in order B (entry 2) then A (entry 0 after free), both ready same cycle -> B issues first.
REQ-033 Hold res_ready=0 with a result pending and a second ready entry -> result stable, no issue; res_ready=1 -> drain and issue same cycle.
REQ-034 flush with 3 valid entries and res_valid=1 -> next cycle res_valid=0, dispatch_ready=1, no issue of stale entries.
